alsu_req_scheduler: RTL and testbench

//  Shares one ALSU instance between two requesters (round-robin). Screens each command,

---
 rtl/alsu_req_scheduler.sv | 156 +++++++++++++++
 tb/tb_alsu_req_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_req_scheduler.sv
// Round-robin arbiter that screens commands from two requesters, issues legal ones to a
// shared ALSU, waits its fixed latency and returns the result over a valid/ready channel.
module alsu_req_scheduler #(
    parameter int ALSU_LAT = 2,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [15:0]         req0_cmd,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [15:0]         req1_cmd,
    output logic [15:0]         alsu_cmd,
    input  logic signed [5:0]   alsu_out,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic signed [5:0]   rsp_out,
    output logic                rsp_err,
    output logic                busy,
    output logic [CNT_W-1:0]    ops_cnt,
    output logic [CNT_W-1:0]    err_cnt
);

    localparam int WCW = (ALSU_LAT > 1) ? $clog2(ALSU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                 state_q, state_d;
    logic [15:0]            cmd_q, cmd_d;
    logic                   last_grant_q, last_grant_d;
    logic                   rsp_id_q, rsp_id_d;
    logic signed [5:0]      rsp_out_q, rsp_out_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [WCW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]       ops_cnt_q, ops_cnt_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

    logic                   winner;
    logic [15:0]            win_cmd;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Reduction flags only make sense for OR/XOR; opcodes 6 and 7 are undefined.
    function automatic logic cmd_legal(input logic [15:0] c);
        logic [2:0] op;
        op = c[15:13];
        if (op == 3'd6 || op == 3'd7) return 1'b0;
        if ((c[3] | c[2]) && op > 3'd1) return 1'b0;
        return 1'b1;
    endfunction

    // Both valid: the requester that did not win last time goes next.
    assign winner  = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    assign win_cmd = winner ? req1_cmd : req0_cmd;

    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_out_d    = rsp_out_q;
        rsp_err_d    = rsp_err_q;
        rsp_valid_d  = rsp_valid_q;
        wait_cnt_d   = wait_cnt_q;
        ops_cnt_d    = ops_cnt_q;
        err_cnt_d    = err_cnt_q;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        alsu_cmd     = 16'd0;

        case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    req0_ready   = ~winner;
                    req1_ready   = winner;
                    cmd_d        = win_cmd;
                    last_grant_d = winner;
                    rsp_id_d     = winner;
                    if (cmd_legal(win_cmd)) begin
                        state_d = ISSUE;
                    end else begin
                        state_d     = RESP;
                        err_cnt_d   = sat_inc(err_cnt_q);
                        rsp_err_d   = 1'b1;
                        rsp_out_d   = 6'sd0;
                        rsp_valid_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                alsu_cmd   = cmd_q;
                ops_cnt_d  = sat_inc(ops_cnt_q);
                wait_cnt_d = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                if (wait_cnt_q == WCW'(ALSU_LAT - 1)) begin
                    rsp_out_d   = alsu_out;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cmd_q        <= 16'd0;
            last_grant_q <= 1'b1;
            rsp_id_q     <= 1'b0;
            rsp_out_q    <= 6'sd0;
            rsp_err_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            wait_cnt_q   <= '0;
            ops_cnt_q    <= '0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_out_q    <= rsp_out_d;
            rsp_err_q    <= rsp_err_d;
            rsp_valid_q  <= rsp_valid_d;
            wait_cnt_q   <= wait_cnt_d;
            ops_cnt_q    <= ops_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);
    assign ops_cnt   = ops_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_alsu_req_scheduler.sv
// Directed bench for alsu_req_scheduler: a two-cycle ALSU model answers each issue,
// and hand-derived expectations cover timing, arbitration, rejection, backpressure and reset.
module tb_alsu_req_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_cmd = 16'd0, req1_cmd = 16'd0;
    logic [15:0] alsu_cmd;
    logic [5:0]  alsu_out;
    logic        rsp_valid, rsp_id, rsp_err, busy;
    logic        rsp_ready = 1'b0;
    logic [5:0]  rsp_out;
    logic [7:0]  ops_cnt, err_cnt;

    int n_chk = 0;
    int n_fail = 0;

    logic [5:0] alsu_res = 6'd0;
    logic       d1 = 1'b0, d2 = 1'b0;

    alsu_req_scheduler #(.ALSU_LAT(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
        .alsu_cmd(alsu_cmd), .alsu_out(alsu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_out(rsp_out), .rsp_err(rsp_err), .busy(busy),
        .ops_cnt(ops_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // ALSU model: result is only valid in the cycle two after the issue cycle, garbage otherwise.
    always @(posedge clk) begin
        d1 <= (alsu_cmd != 16'd0);
        d2 <= d1;
    end
    assign alsu_out = d2 ? alsu_res : 6'h15;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                       input logic [2:0] b, input logic [6:0] f);
        return {op, a, b, f};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_dut();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits (bounded) for the response, records it and completes the handshake.
    task automatic get_rsp(input string tag, output logic [5:0] o_out, output logic o_err,
                           output logic o_id);
        int k;
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk({tag, "_rsp_timeout"}, 32'(k < 20), 32'd1);
        o_out = rsp_out;
        o_err = rsp_err;
        o_id  = rsp_id;
        rsp_ready = 1'b1;
        tick();
    endtask

    task automatic run_txn(input logic id, input logic [15:0] cmd, output logic [5:0] o_out,
                           output logic o_err, output logic o_id);
        int k;
        if (id) begin req1_cmd = cmd; req1_valid = 1'b1; end
        else    begin req0_cmd = cmd; req0_valid = 1'b1; end
        #1;
        k = 0;
        while (!(id ? req1_ready : req0_ready) && k < 20) begin
            tick();
            #1;
            k++;
        end
        chk("txn_grant_timeout", 32'(k < 20), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        get_rsp("txn", o_out, o_err, o_id);
    endtask

    initial begin : main
        logic [5:0]  g_out, s_out;
        logic        g_err, g_id, s_err, s_id, win, both_hi, stable;
        logic [15:0] c;
        int          k;

        // Reset state
        tick();
        tick();
        chk("rst_alsu_cmd", 32'(alsu_cmd), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_out", 32'(rsp_out), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ops", 32'(ops_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // 1: ADD 3 + -4 -> -1, exact cycle timing
        alsu_res   = 6'h3F;
        c          = mk(3'd2, 3'd3, 3'b100, 7'd0);
        req0_cmd   = c;
        req0_valid = 1'b1;
        #1;
        chk("t1_req0_ready", 32'(req0_ready), 32'd1);
        chk("t1_req1_ready", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        chk("t1_issue_cmd", 32'(alsu_cmd), 32'(c));
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_t2_cmd_idle", 32'(alsu_cmd), 32'd0);
        chk("t1_t2_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_t3_no_rsp", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_t4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t1_rsp_id", 32'(rsp_id), 32'd0);
        chk("t1_rsp_out", 32'(rsp_out), 32'h3F);
        chk("t1_rsp_err", 32'(rsp_err), 32'd0);
        chk("t1_ops", 32'(ops_cnt), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("t1_rsp_dropped", 32'(rsp_valid), 32'd0);
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: both requesters continuously valid -> 0,1,0,1
        reset_dut();
        rsp_ready  = 1'b1;
        alsu_res   = 6'h07;
        req0_cmd   = mk(3'd2, 3'd1, 3'd1, 7'd0);
        req1_cmd   = mk(3'd3, 3'd2, 3'd2, 7'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        both_hi    = 1'b0;
        for (int g = 0; g < 4; g++) begin
            #1;
            k = 0;
            while (!(req0_ready | req1_ready) && k < 30) begin
                tick();
                #1;
                k++;
            end
            chk("t2_grant_timeout", 32'(k < 30), 32'd1);
            if (req0_ready && req1_ready) both_hi = 1'b1;
            win = req1_ready;
            chk("t2_order", 32'(win), 32'(g % 2));
            tick();
            get_rsp("t2", g_out, g_err, g_id);
            chk("t2_rsp_id", 32'(g_id), 32'(g % 2));
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("t2_single_ready", 32'(both_hi), 32'd0);
        chk("t2_ops", 32'(ops_cnt), 32'd4);

        // 3: illegal commands from req1 (opcode 7, ADD with red_op_A)
        for (int i = 0; i < 2; i++) begin
            req1_cmd   = (i == 0) ? mk(3'd7, 3'd1, 3'd1, 7'd0) : mk(3'd2, 3'd1, 3'd1, 7'b0001000);
            req1_valid = 1'b1;
            #1;
            chk("t3_req1_ready", 32'(req1_ready), 32'd1);
            tick();
            req1_valid = 1'b0;
            chk("t3_no_issue", 32'(alsu_cmd), 32'd0);
            chk("t3_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("t3_rsp_err", 32'(rsp_err), 32'd1);
            chk("t3_rsp_out", 32'(rsp_out), 32'd0);
            chk("t3_rsp_id", 32'(rsp_id), 32'd1);
            chk("t3_err_cnt", 32'(err_cnt), 32'(i + 1));
            tick();
            chk("t3_rsp_done", 32'(rsp_valid), 32'd0);
        end
        chk("t3_ops_unchanged", 32'(ops_cnt), 32'd4);

        // 4: response backpressure
        rsp_ready  = 1'b0;
        alsu_res   = 6'h2B;
        req0_cmd   = mk(3'd4, 3'd5, 3'd2, 7'b0010000);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 20) begin
            tick();
            k++;
        end
        chk("t4_rsp_timeout", 32'(k < 20), 32'd1);
        s_out      = rsp_out;
        s_err      = rsp_err;
        s_id       = rsp_id;
        req1_cmd   = mk(3'd5, 3'd6, 3'd1, 7'd0);
        req1_valid = 1'b1;
        stable     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!rsp_valid || rsp_out != s_out || rsp_err != s_err || rsp_id != s_id ||
                req0_ready || req1_ready || alsu_cmd != 16'd0) stable = 1'b0;
        end
        chk("t4_stable", 32'(stable), 32'd1);
        chk("t4_rsp_out", 32'(s_out), 32'h2B);
        chk("t4_rsp_id", 32'(s_id), 32'd0);
        rsp_ready = 1'b1;
        #1;
        chk("t4_no_grant_in_hs", 32'(req1_ready), 32'd0);
        tick();
        #1;
        chk("t4_grant_after_hs", 32'(req1_ready), 32'd1);
        chk("t4_rsp_cleared", 32'(rsp_valid), 32'd0);
        tick();
        req1_valid = 1'b0;
        get_rsp("t4b", g_out, g_err, g_id);
        chk("t4b_rsp_id", 32'(g_id), 32'd1);

        // 5: reset during WAIT; req0 first afterwards
        run_txn(1'b0, mk(3'd1, 3'd2, 3'd3, 7'd0), g_out, g_err, g_id);
        req0_cmd   = mk(3'd2, 3'd2, 3'd2, 7'd0);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_alsu_cmd", 32'(alsu_cmd), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_ops", 32'(ops_cnt), 32'd0);
        chk("t5_err", 32'(err_cnt), 32'd0);
        @(negedge clk);
        rst        = 1'b0;
        req1_cmd   = mk(3'd3, 3'd1, 3'd1, 7'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        chk("t5_req0_first", 32'(req0_ready), 32'd1);
        chk("t5_req1_wait", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        get_rsp("t5", g_out, g_err, g_id);
        chk("t5_rsp_id", 32'(g_id), 32'd0);

        // 6: ops counter saturation
        reset_dut();
        alsu_res = 6'h01;
        for (int i = 0; i < 255; i++) run_txn(i[0], mk(3'd0, 3'd1, 3'd1, 7'd0), g_out, g_err, g_id);
        chk("t6_ops_255", 32'(ops_cnt), 32'd255);
        run_txn(1'b0, mk(3'd0, 3'd1, 3'd1, 7'd0), g_out, g_err, g_id);
        chk("t6_ops_sat", 32'(ops_cnt), 32'd255);
        chk("t6_last_rsp", 32'(g_out), 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
